seg7_scan_reader: RTL and testbench

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

---
 rtl/seg7_pkg.sv | 62 ++++++
 rtl/seg7_pat_decode.sv | 30 +++
 rtl/seg7_scan_reader.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment glyph constants, scan FSM state type and glyph decode function
package seg7_pkg;

    // Segment order a..g maps to bits 6..0, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_STAB = 2'd1,
        ST_HOLD = 2'd2
    } seg7_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
        seg7_dec_t d;
        d.legal = 1'b1;
        d.value = 4'h0;
        case (seg)
            SEG_0:   d.value = 4'h0;
            SEG_1:   d.value = 4'h1;
            SEG_2:   d.value = 4'h2;
            SEG_3:   d.value = 4'h3;
            SEG_4:   d.value = 4'h4;
            SEG_5:   d.value = 4'h5;
            SEG_6:   d.value = 4'h6;
            SEG_7:   d.value = 4'h7;
            SEG_8:   d.value = 4'h8;
            SEG_9:   d.value = 4'h9;
            SEG_A:   d.value = 4'hA;
            SEG_B:   d.value = 4'hB;
            SEG_C:   d.value = 4'hC;
            SEG_D:   d.value = 4'hD;
            SEG_E:   d.value = 4'hE;
            SEG_F:   d.value = 4'hF;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_pat_decode.sv
// rtl/seg7_pat_decode.sv - combinational segment pattern to nibble decode with legal flag (blank glyph under SEG7_RD_BLANK_EN)
module seg7_pat_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
`ifdef SEG7_RD_BLANK_EN
    output logic       blank,
`endif
    output logic       legal
);

    seg7_dec_t dec;

    always_comb begin
        dec   = seg7_decode(seg);
        value = dec.value;
        legal = dec.legal;
`ifdef SEG7_RD_BLANK_EN
        blank = 1'b0;
        // An unlit digit reads as F so a blank position never aliases a real 0.
        if (seg == SEG_BLANK) begin
            value = 4'hF;
            legal = 1'b1;
            blank = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - samples a multiplexed 7-segment display and rebuilds the shown hex value; SEG7_RD_BLANK_EN enables blank digits
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_i,
    input  logic [NUM_DIG-1:0]   an_i,
    output logic [4*NUM_DIG-1:0] value_o,
    output logic                 valid_o,
`ifdef SEG7_RD_BLANK_EN
    output logic [NUM_DIG-1:0]   blank_o,
`endif
    output logic                 err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CNT);

    logic [6:0]           seg_s1, seg_s2, prev_seg;
    logic [NUM_DIG-1:0]   an_s1, an_s2, prev_an;
    seg7_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 accept;
    logic                 one_hot, same;

    logic [3:0]           dec_value;
    logic                 dec_legal;
    logic [NUM_DIG-1:0]   seen, seen_upd, acc_mask;
    logic [4*NUM_DIG-1:0] slots, slots_upd;
    logic                 frame_done;
`ifdef SEG7_RD_BLANK_EN
    logic                 dec_blank;
    logic [NUM_DIG-1:0]   blanks, blanks_upd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            an_s1    <= '0;
            an_s2    <= '0;
            prev_seg <= '0;
            prev_an  <= '0;
        end else begin
            seg_s1   <= seg_i;
            seg_s2   <= seg_s1;
            an_s1    <= an_i;
            an_s2    <= an_s1;
            prev_seg <= seg_s2;
            prev_an  <= an_s2;
        end
    end

    assign one_hot = $onehot(an_s2);
    assign same    = (an_s2 == prev_an) && (seg_s2 == prev_seg);

    seg7_pat_decode u_pat_decode (
        .seg   (seg_s2),
        .value (dec_value),
`ifdef SEG7_RD_BLANK_EN
        .blank (dec_blank),
`endif
        .legal (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter tracks how many consecutive identical samples this dwell has shown.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (one_hot) begin
                    state_nxt = ST_STAB;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_STAB: begin
                if (same) begin
                    if (cnt == CNT_LAST) begin
                        accept    = 1'b1;
                        state_nxt = ST_HOLD;
                        cnt_nxt   = CNT_FULL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (one_hot) begin
                    cnt_nxt = CNT_W'(1);
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    if (one_hot) begin
                        state_nxt = ST_STAB;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The one-hot enable doubles as the slot write mask.
    always_comb begin
        acc_mask  = (accept && dec_legal) ? an_s2 : '0;
        seen_upd  = seen | acc_mask;
        slots_upd = slots;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (acc_mask[k]) begin
                slots_upd[4*k +: 4] = dec_value;
            end
        end
    end

`ifdef SEG7_RD_BLANK_EN
    always_comb begin
        blanks_upd = blanks;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (acc_mask[k]) begin
                blanks_upd[k] = dec_blank;
            end
        end
    end
`endif

    assign frame_done = (|acc_mask) && (&seen_upd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen    <= '0;
            slots   <= '0;
            value_o <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            slots   <= slots_upd;
            seen    <= frame_done ? '0 : seen_upd;
            valid_o <= frame_done;
            err_o   <= accept && !dec_legal;
            if (frame_done) begin
                value_o <= slots_upd;
            end
        end
    end

`ifdef SEG7_RD_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blanks  <= '0;
            blank_o <= '0;
        end else begin
            blanks <= blanks_upd;
            if (frame_done) begin
                blank_o <= blanks_upd;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - self-checking bench for seg7_scan_reader (glyph table, corner sequences, randomized scans)
module tb_seg7_scan_reader;

    localparam int NUM_DIG    = 4;
    localparam int STABLE_CNT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic [15:0] value_o;
    logic        valid_o;
    logic        err_o;
`ifdef SEG7_RD_BLANK_EN
    logic [3:0]  blank_o;
`endif

    seg7_scan_reader #(.NUM_DIG(NUM_DIG), .STABLE_CNT(STABLE_CNT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_i   (seg_i),
        .an_i    (an_i),
        .value_o (value_o),
        .valid_o (valid_o),
`ifdef SEG7_RD_BLANK_EN
        .blank_o (blank_o),
`endif
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct packed {
        logic [6:0]  s3, s2, s1, s0;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [4];

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt, err_cnt, both_cnt;
    logic [15:0] got_val [$];
`ifdef SEG7_RD_BLANK_EN
    logic [3:0]  got_blank [$];
`endif

    initial begin
        valid_cnt = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                valid_cnt++;
                got_val.push_back(value_o);
`ifdef SEG7_RD_BLANK_EN
                got_blank.push_back(blank_o);
`endif
            end
            if (err_o) err_cnt++;
            if (valid_o && err_o) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        err_cnt   = 0;
        got_val.delete();
`ifdef SEG7_RD_BLANK_EN
        got_blank.delete();
`endif
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(negedge clk);
        an_i  = an;
        seg_i = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic idle(input int n);
        dwell(4'b0000, 7'h00, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        an_i  = '0;
        seg_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic model_dec(input logic [6:0] seg, output logic legal, output logic [3:0] nib,
                             output logic blank);
        legal = 1'b0;
        nib   = 4'h0;
        blank = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (glyph[j] == seg) begin
                legal = 1'b1;
                nib   = 4'(j);
            end
        end
`ifdef SEG7_RD_BLANK_EN
        if (seg == 7'h00) begin
            legal = 1'b1;
            nib   = 4'hF;
            blank = 1'b1;
        end
`endif
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ra_q [$];
        logic [6:0]  rs_q [$];
        int          rl_q [$];
        logic [15:0] exp_val [$];
        logic [3:0]  exp_blank [$];
        logic [15:0] m_slot;
        logic [3:0]  m_seen, m_blank;
        int          exp_err, lat, nmin;
        logic [3:0]  pa, a;
        logic [6:0]  ps, s;
        logic        lg, bl;
        logic [3:0]  nb;

        vecs[0] = '{7'h79, 7'h6D, 7'h30, 7'h7E, 16'h3210};
        vecs[1] = '{7'h70, 7'h5F, 7'h5B, 7'h33, 16'h7654};
        vecs[2] = '{7'h1F, 7'h77, 7'h7B, 7'h7F, 16'hBA98};
        vecs[3] = '{7'h47, 7'h4F, 7'h3D, 7'h4E, 16'hFEDC};

        rst_n = 1'b0;
        an_i  = '0;
        seg_i = '0;
        repeat (3) @(negedge clk);
        check("reset_value", value_o, 16'h0000);
        check("reset_valid", valid_o, 1'b0);
        check("reset_err", err_o, 1'b0);
        rst_n = 1'b1;
        clear_mon();

        for (int i = 0; i < 4; i++) begin
            clear_mon();
            dwell(4'b0001, vecs[i].s0, 5);
            dwell(4'b0010, vecs[i].s1, 5);
            dwell(4'b0100, vecs[i].s2, 5);
            dwell(4'b1000, vecs[i].s3, 5);
            idle(4);
            check($sformatf("vec%0d_valid_cnt", i), valid_cnt, 1);
            check($sformatf("vec%0d_value", i), value_o, vecs[i].exp);
            check($sformatf("vec%0d_err", i), err_cnt, 0);
        end

        do_reset();
        dwell(4'b0001, glyph[4], 5);
        dwell(4'b0010, glyph[3], 5);
        dwell(4'b0100, glyph[2], 5);
        dwell(4'b1000, glyph[1], 5);
        idle(4);
        check("scan1234_valid_cnt", valid_cnt, 1);
        check("scan1234_value", value_o, 16'h1234);
        check("scan1234_err", err_cnt, 0);

        do_reset();
        dwell(4'b0001, glyph[0], 5);
        dwell(4'b0010, glyph[1], 5);
        dwell(4'b0100, glyph[2], 5);
        idle(4);
        @(negedge clk);
        an_i  = 4'b1000;
        seg_i = glyph[9];
        lat   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid_o && lat == 0) lat = k;
        end
        check("latency", lat, 2 + STABLE_CNT);
        idle(4);
        check("latency_value", value_o, 16'h9210);

        do_reset();
        dwell(4'b0001, glyph[5], 5);
        dwell(4'b0010, glyph[6], 5);
        dwell(4'b0100, glyph[7], STABLE_CNT - 1);
        dwell(4'b1000, glyph[8], 5);
        idle(4);
        check("short_dwell_no_valid", valid_cnt, 0);
        dwell(4'b0100, glyph[7], 5);
        idle(4);
        check("short_dwell_later_valid", valid_cnt, 1);
        check("short_dwell_value", value_o, 16'h8765);

        do_reset();
        dwell(4'b0001, glyph[1], 5);
        dwell(4'b0010, glyph[2], 5);
        dwell(4'b0100, 7'h01, 5);
        dwell(4'b1000, glyph[3], 5);
        idle(4);
        check("illegal_err_cnt", err_cnt, 1);
        check("illegal_no_valid", valid_cnt, 0);

        do_reset();
        dwell(4'b0011, glyph[6], 10);
        idle(4);
        check("multi_an_err", err_cnt, 0);
        check("multi_an_valid", valid_cnt, 0);
        dwell(4'b0100, glyph[2], 5);
        dwell(4'b1000, glyph[3], 5);
        dwell(4'b0001, glyph[4], 5);
        idle(4);
        check("multi_an_no_digit1", valid_cnt, 0);
        dwell(4'b0010, glyph[5], 5);
        idle(4);
        check("multi_an_frame_valid", valid_cnt, 1);
        check("multi_an_frame_value", value_o, 16'h3254);

        do_reset();
        dwell(4'b0001, glyph[13], 5);
        dwell(4'b0010, glyph[12], 5);
        dwell(4'b0100, glyph[11], 5);
        do_reset();
        dwell(4'b1000, glyph[10], 5);
        idle(4);
        check("reset_discard_no_valid", valid_cnt, 0);
        dwell(4'b0001, glyph[13], 5);
        dwell(4'b0010, glyph[12], 5);
        dwell(4'b0100, glyph[11], 5);
        idle(4);
        check("reset_discard_valid_cnt", valid_cnt, 1);
        check("reset_discard_value", value_o, 16'hABCD);

        do_reset();
        dwell(4'b0001, glyph[0], 5);
        dwell(4'b0010, glyph[0], 5);
        dwell(4'b0100, glyph[7], 5);
        dwell(4'b1000, 7'h00, 5);
        idle(4);
`ifdef SEG7_RD_BLANK_EN
        check("blank_valid_cnt", valid_cnt, 1);
        check("blank_value", value_o, 16'hF700);
        check("blank_mask", blank_o, 4'b1000);
        check("blank_err", err_cnt, 0);
`else
        check("blank_illegal_err", err_cnt, 1);
        check("blank_illegal_no_valid", valid_cnt, 0);
`endif

        // Randomized dwells scored at the dwell level: a one-hot run of at least
        // STABLE_CNT identical samples is one acceptance, anything else is ignored.
        do_reset();
        pa = 4'b0000;
        ps = 7'h00;
        for (int i = 0; i < 250; i++) begin
            do begin
                if ($urandom_range(0, 9) < 8) a = 4'(1 << $urandom_range(0, 3));
                else                          a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) < 8) s = glyph[$urandom_range(0, 15)];
                else                          s = 7'($urandom_range(0, 127));
            end while (a == pa && s == ps);
            ra_q.push_back(a);
            rs_q.push_back(s);
            rl_q.push_back(int'($urandom_range(1, 6)));
            pa = a;
            ps = s;
        end
        for (int i = 0; i < 250; i++) dwell(ra_q[i], rs_q[i], rl_q[i]);
        idle(6);

        m_slot  = '0;
        m_seen  = '0;
        m_blank = '0;
        exp_err = 0;
        for (int i = 0; i < 250; i++) begin
            if ($countones(ra_q[i]) == 1 && rl_q[i] >= STABLE_CNT) begin
                model_dec(rs_q[i], lg, nb, bl);
                if (!lg) begin
                    exp_err++;
                end else begin
                    for (int k = 0; k < NUM_DIG; k++) begin
                        if (ra_q[i][k]) begin
                            m_slot[4*k +: 4] = nb;
                            m_blank[k]       = bl;
                            m_seen[k]        = 1'b1;
                        end
                    end
                    if (m_seen == 4'b1111) begin
                        exp_val.push_back(m_slot);
                        exp_blank.push_back(m_blank);
                        m_seen = '0;
                    end
                end
            end
        end
        check("rand_frame_count", got_val.size(), exp_val.size());
        check("rand_err_count", err_cnt, exp_err);
        nmin = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("rand_frame%0d_value", i), got_val[i], exp_val[i]);
`ifdef SEG7_RD_BLANK_EN
            check($sformatf("rand_frame%0d_blank", i), got_blank[i], exp_blank[i]);
`endif
        end

        check("valid_err_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
